cube_tile_renderer: RTL and testbench

- Parametrised successor to the per-cube face generator in the pixel pipeline.
- For every pixel it classifies the position as top, left or right face of an isometric cube, or none. The cube is defined by its offset, its side length and a half-diagonal, and the face edges use a power-of-two slope.
- It holds a multi-level top-colour state for N_CUBE cubes. Levels advance through a move/land handshake with the Q*bert movement logic, using a selectable update mode.
- Face and level outputs feed the colour mux ahead of the VGA/LCD output stage.

---
 rtl/cube_tile_renderer.sv | 201 ++++++++++++++++++++
 tb/tb_cube_tile_renderer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_tile_renderer.sv
// Isometric cube face classifier with a 2-stage pixel pipeline and a
// per-cube top-colour level store advanced by the move/land handshake.
module cube_tile_renderer #(
  parameter int unsigned N_CUBE      = 28,
  parameter int unsigned N_LEVEL     = 3,
  parameter int unsigned XW          = 11,
  parameter int unsigned YW          = 10,
  parameter int unsigned SLOPE_SHIFT = 1,
  parameter int unsigned IW          = $clog2(N_CUBE),
  parameter int unsigned LW          = (N_LEVEL > 2) ? $clog2(N_LEVEL) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XW-1:0]      x_cnt,
  input  logic [YW-1:0]      y_cnt,
  input  logic [XW+YW-1:0]   xy_offset,
  input  logic [XW-1:0]      x_length,
  input  logic [XW-1:0]      diag_dx,
  input  logic [N_CUBE-1:0]  hb_top,
  input  logic               move_start,
  input  logic [IW-1:0]      land_idx,
  input  logic [1:0]         cfg_mode,
  input  logic               done_move,
  input  logic               level_clear,
  output logic               top_face,
  output logic               left_face,
  output logic               right_face,
  output logic [LW-1:0]      top_level,
  output logic               all_done,
  output logic               busy
);

  localparam int unsigned SW = XW + YW + 2;
  localparam logic [LW-1:0] TOP_LVL = LW'(N_LEVEL - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LAND, COMMIT} state_t;

  // Geometry in a signed width wide enough that no sum or difference wraps
  logic signed [SW-1:0] xs, ys, x0, y0, ls, dx, dy, mid, far, d, h;
  logic                 in_rise, in_fall;

  assign xs  = signed'(SW'(x_cnt));
  assign ys  = signed'(SW'(y_cnt));
  assign x0  = signed'(SW'(xy_offset[XW+YW-1:YW]));
  assign y0  = signed'(SW'(xy_offset[YW-1:0]));
  assign ls  = signed'(SW'(x_length));
  assign dx  = signed'(SW'(diag_dx));
  assign dy  = dx <<< SLOPE_SHIFT;
  assign mid = y0 + dy;
  assign far = mid + dy;

  assign in_rise = (ys >= y0) && (ys <= mid);
  assign in_fall = (ys > mid) && (ys <= far);
  assign d       = in_rise ? (ys - y0) : (far - ys);
  assign h       = d >>> SLOPE_SHIFT;

  logic [LW-1:0] lvl [N_CUBE];
  logic [LW-1:0] sel_lvl;

  // Level of the lowest-indexed selected cube
  always_comb begin
    sel_lvl = '0;
    for (int i = int'(N_CUBE) - 1; i >= 0; i--) begin
      if (hb_top[i]) sel_lvl = lvl[i];
    end
  end

  logic                 s1_valid, s1_right;
  logic signed [SW-1:0] s1_x, s1_lo, s1_hi_top, s1_hi_side;
  logic [LW-1:0]        s1_lvl;

  // Stage 1: window bounds and level lookup
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_right   <= 1'b0;
      s1_x       <= '0;
      s1_lo      <= '0;
      s1_hi_top  <= '0;
      s1_hi_side <= '0;
      s1_lvl     <= '0;
    end else begin
      s1_valid   <= in_rise || in_fall;
      s1_right   <= ys < mid;
      s1_x       <= xs;
      s1_lo      <= x0 - h;
      s1_hi_top  <= x0 + h;
      s1_hi_side <= x0 + ls + h;
      s1_lvl     <= sel_lvl;
    end
  end

  logic top_c, side_c;
  assign top_c  = s1_valid && (s1_x >= s1_lo) && (s1_x <= s1_hi_top);
  assign side_c = s1_valid && !top_c && (s1_x > s1_hi_top) && (s1_x <= s1_hi_side);

  // Stage 2: face compares
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_face   <= 1'b0;
      left_face  <= 1'b0;
      right_face <= 1'b0;
      top_level  <= '0;
    end else begin
      top_face   <= top_c;
      left_face  <= side_c && !s1_right;
      right_face <= side_c && s1_right;
      top_level  <= s1_lvl;
    end
  end

  state_t        state, state_nxt;
  logic          lat_en;
  logic [IW-1:0] lat_idx;
  logic [1:0]    lat_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      lat_idx  <= '0;
      lat_mode <= '0;
    end else begin
      state <= state_nxt;
      busy  <= state_nxt != IDLE;
      if (lat_en) begin
        lat_idx  <= land_idx;
        lat_mode <= cfg_mode;
      end
    end
  end

  // Next state; level_clear overrides any handshake activity
  always_comb begin
    state_nxt = state;
    lat_en    = 1'b0;
    case (state)
      IDLE: begin
        if (move_start) begin
          state_nxt = WAIT_LAND;
          lat_en    = 1'b1;
        end
      end
      WAIT_LAND: if (done_move) state_nxt = COMMIT;
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (level_clear) begin
      state_nxt = IDLE;
      lat_en    = 1'b0;
    end
  end

  logic [LW-1:0] cur_lvl, new_lvl;
  logic          commit_c;

  always_comb begin
    cur_lvl = '0;
    for (int i = 0; i < int'(N_CUBE); i++) begin
      if (lat_idx == IW'(i)) cur_lvl = lvl[i];
    end
  end

  always_comb begin
    new_lvl = cur_lvl;
    case (lat_mode)
      2'd1:    new_lvl = (cur_lvl == TOP_LVL) ? '0 : cur_lvl + LW'(1);
      2'd2:    new_lvl = (cur_lvl == TOP_LVL) ? cur_lvl - LW'(1) : cur_lvl + LW'(1);
      default: new_lvl = (cur_lvl == TOP_LVL) ? cur_lvl : cur_lvl + LW'(1);
    endcase
  end

  assign commit_c = (state == COMMIT) && !level_clear;

  // Out-of-range latched indices match no entry, so nothing is written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_CUBE); i++) lvl[i] <= '0;
    end else if (level_clear) begin
      for (int i = 0; i < int'(N_CUBE); i++) lvl[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_CUBE); i++) begin
        if (commit_c && (lat_idx == IW'(i))) lvl[i] <= new_lvl;
      end
    end
  end

  logic all_c;
  always_comb begin
    all_c = 1'b1;
    for (int i = 0; i < int'(N_CUBE); i++) begin
      if (lvl[i] != TOP_LVL) all_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) all_done <= 1'b0;
    else        all_done <= all_c;
  end

endmodule

// File: tb/tb_cube_tile_renderer.sv
// Directed bench for cube_tile_renderer: face table plus level-handshake sequences.
module tb_cube_tile_renderer;

  localparam int unsigned N_CUBE = 28;
  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned IW = 5;
  localparam int unsigned LW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [XW+YW-1:0]  xy_offset;
  logic [XW-1:0]     x_length;
  logic [XW-1:0]     diag_dx;
  logic [N_CUBE-1:0] hb_top;
  logic              move_start;
  logic [IW-1:0]     land_idx;
  logic [1:0]        cfg_mode;
  logic              done_move;
  logic              level_clear;
  logic              top_face, left_face, right_face;
  logic [LW-1:0]     top_level;
  logic              all_done, busy;

  int total = 0;
  int bad   = 0;

  cube_tile_renderer dut (
    .clk        (clk),
    .reset      (rst_n),
    .x_cnt      (x_cnt),
    .y_cnt      (y_cnt),
    .xy_offset  (xy_offset),
    .x_length   (x_length),
    .diag_dx    (diag_dx),
    .hb_top     (hb_top),
    .move_start (move_start),
    .land_idx   (land_idx),
    .cfg_mode   (cfg_mode),
    .done_move  (done_move),
    .level_clear(level_clear),
    .top_face   (top_face),
    .left_face  (left_face),
    .right_face (right_face),
    .top_level  (top_level),
    .all_done   (all_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          t;
    logic          l;
    logic          r;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic do_move(input logic [IW-1:0] idx, input logic [1:0] mode);
    @(negedge clk);
    move_start = 1'b1;
    land_idx   = idx;
    cfg_mode   = mode;
    @(negedge clk);
    move_start = 1'b0;
    chk("busy_wait", int'(busy), 1);
    @(negedge clk);
    done_move = 1'b1;
    @(negedge clk);
    done_move = 1'b0;
    chk("busy_commit", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic check_level(input int idx, input int exp);
    hb_top = '0;
    hb_top[idx] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("level[%0d]", idx), int'(top_level), exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    x_cnt       = '0;
    y_cnt       = '0;
    xy_offset   = {11'd100, 10'd200};
    x_length    = 11'd50;
    diag_dx     = 11'd20;
    hb_top      = '0;
    move_start  = 1'b0;
    land_idx    = '0;
    cfg_mode    = '0;
    done_move   = 1'b0;
    level_clear = 1'b0;

    vecs[0] = '{x: 11'd100, y: 10'd240, t: 1'b1, l: 1'b0, r: 1'b0};
    vecs[1] = '{x: 11'd125, y: 10'd220, t: 1'b0, l: 1'b0, r: 1'b1};
    vecs[2] = '{x: 11'd125, y: 10'd260, t: 1'b0, l: 1'b1, r: 1'b0};
    vecs[3] = '{x: 11'd100, y: 10'd281, t: 1'b0, l: 1'b0, r: 1'b0};
    vecs[4] = '{x: 11'd161, y: 10'd220, t: 1'b0, l: 1'b0, r: 1'b0};
    vecs[5] = '{x: 11'd110, y: 10'd220, t: 1'b1, l: 1'b0, r: 1'b0};
    vecs[6] = '{x: 11'd111, y: 10'd220, t: 1'b0, l: 1'b0, r: 1'b1};
    vecs[7] = '{x: 11'd110, y: 10'd240, t: 1'b1, l: 1'b0, r: 1'b0};
    vecs[8] = '{x: 11'd130, y: 10'd240, t: 1'b0, l: 1'b1, r: 1'b0};
    vecs[9] = '{x: 11'd160, y: 10'd280, t: 1'b0, l: 1'b0, r: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_top", int'(top_face), 0);
    chk("rst_left", int'(left_face), 0);
    chk("rst_right", int'(right_face), 0);
    chk("rst_level", int'(top_level), 0);
    chk("rst_all_done", int'(all_done), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Face classification, two-cycle latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x_cnt = vecs[i].x;
      y_cnt = vecs[i].y;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk($sformatf("top_v%0d", i), int'(top_face), int'(vecs[i].t));
      chk($sformatf("left_v%0d", i), int'(left_face), int'(vecs[i].l));
      chk($sformatf("right_v%0d", i), int'(right_face), int'(vecs[i].r));
      chk($sformatf("onehot_v%0d", i),
          int'(top_face) + int'(left_face) + int'(right_face) <= 1 ? 1 : 0, 1);
    end

    // Mode 0 saturating on cube 5: 1, 2, 2
    do_move(5'd5, 2'd0);
    check_level(5, 1);
    do_move(5'd5, 2'd0);
    check_level(5, 2);
    do_move(5'd5, 2'd0);
    check_level(5, 2);

    // Mode 1 wraps 2 -> 0
    do_move(5'd5, 2'd1);
    check_level(5, 0);
    do_move(5'd5, 2'd0);
    do_move(5'd5, 2'd0);
    check_level(5, 2);

    // Mode 2 reverts 2 -> 1, then advances 1 -> 2
    do_move(5'd5, 2'd2);
    check_level(5, 1);
    do_move(5'd5, 2'd2);
    check_level(5, 2);

    // Out-of-range land index writes nothing
    do_move(5'd28, 2'd0);
    check_level(5, 2);
    check_level(0, 0);
    check_level(27, 0);

    // Lowest set bit wins; empty select reads 0
    hb_top = '0;
    hb_top[5] = 1'b1;
    hb_top[9] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("multi_hot_level", int'(top_level), 2);
    hb_top = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_select_level", int'(top_level), 0);

    // Fill every cube; all_done rises the cycle after the final commit
    for (int i = 0; i < int'(N_CUBE) - 1; i++) begin
      do_move(IW'(i), 2'd0);
      do_move(IW'(i), 2'd0);
    end
    do_move(5'd27, 2'd0);
    chk("all_done_partial", int'(all_done), 0);
    do_move(5'd27, 2'd0);
    chk("all_done_at_commit", int'(all_done), 0);
    @(posedge clk);
    #1;
    chk("all_done_after", int'(all_done), 1);
    check_level(13, 2);

    // level_clear beats done_move in the same cycle
    @(negedge clk);
    move_start = 1'b1;
    land_idx   = 5'd3;
    cfg_mode   = 2'd1;
    @(negedge clk);
    move_start = 1'b0;
    chk("clr_busy_before", int'(busy), 1);
    @(negedge clk);
    done_move   = 1'b1;
    level_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_busy_drop", int'(busy), 0);
    @(negedge clk);
    done_move   = 1'b0;
    level_clear = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_all_done", int'(all_done), 0);
    chk("clr_busy_stays", int'(busy), 0);
    check_level(3, 0);
    check_level(5, 0);
    check_level(27, 0);

    // Reset during WAIT_LAND aborts the pending update
    x_cnt = 11'd100;
    y_cnt = 10'd240;
    do_move(5'd5, 2'd0);
    check_level(5, 1);
    chk("pre_rst_top", int'(top_face), 1);
    @(negedge clk);
    move_start = 1'b1;
    land_idx   = 5'd5;
    cfg_mode   = 2'd0;
    @(negedge clk);
    move_start = 1'b0;
    chk("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_top", int'(top_face), 0);
    chk("mid_rst_left", int'(left_face), 0);
    chk("mid_rst_right", int'(right_face), 0);
    chk("mid_rst_level", int'(top_level), 0);
    chk("mid_rst_all_done", int'(all_done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_move = 1'b1;
    @(negedge clk);
    done_move = 1'b0;
    chk("post_rst_busy", int'(busy), 0);
    check_level(5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
